// File: rtl/pic_stream_pattern_gen.sv
// pic_stream_pattern_gen
// Video-stream source for the vsync/href/clken + 8-bit luma interface.
// Generates frame timing (vsync, back porch, active lines, front porch,
// horizontal blanking) and one of four synthetic luma patterns.
// Optional build macro: PIX_GAP_EN -- each pixel spans two cycles, with
// clken high only on the first cycle of the pair.
module pic_stream_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 20,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] const_val,
  output logic       per_frame_vsync,
  output logic       per_frame_href,
  output logic       per_frame_clken,
  output logic [7:0] per_img_y,
  output logic       frame_done
);

`ifdef PIX_GAP_EN
  localparam int PIX_SHIFT = 1;
`else
  localparam int PIX_SHIFT = 0;
`endif

  localparam int HREF_LEN = H_ACTIVE << PIX_SHIFT;
  localparam int H_TOTAL  = HREF_LEN + H_BLANK;
  localparam int V_MAX01  = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int V_MAX23  = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX    = (V_MAX01 > V_MAX23) ? V_MAX01 : V_MAX23;
  localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HREF_END = HW'(HREF_LEN);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   h_reg, h_next;
  logic [VW-1:0]   v_reg, v_next, v_last;
  logic [1:0]      sel_reg;
  logic [7:0]      cval_reg;

  logic            vsync_next, href_next, clken_next, done_next;
  logic [7:0]      y_next, x8, y8;

  // Last line index of whichever vertical region the FSM is in
  always_comb begin
    v_last = '0;
    case (state_reg)
      VSYNC:   v_last = VW'(V_SYNC - 1);
      VBP:     v_last = VW'(V_BP - 1);
      ACTIVE:  v_last = VW'(V_ACTIVE - 1);
      VFP:     v_last = VW'(V_FP - 1);
      default: v_last = '0;
    endcase
  end

  // Next position in the frame: state, line-within-state and h counter
  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    v_next     = v_reg;
    if (state_reg == IDLE) begin
      if (enable) begin
        state_next = VSYNC;
        h_next     = '0;
        v_next     = '0;
      end
    end else if (h_reg == H_LAST) begin
      h_next = '0;
      if (v_reg == v_last) begin
        v_next = '0;
        case (state_reg)
          VSYNC:   state_next = VBP;
          VBP:     state_next = ACTIVE;
          ACTIVE:  state_next = VFP;
          VFP:     state_next = enable ? VSYNC : IDLE;
          default: state_next = IDLE;
        endcase
      end else begin
        v_next = v_reg + 1'b1;
      end
    end else begin
      h_next = h_reg + 1'b1;
    end
  end

  // Output values for the upcoming position, so every output is a flop
  always_comb begin
    x8         = 8'(h_next >> PIX_SHIFT);
    y8         = 8'(v_next);
    vsync_next = (state_next == VSYNC);
    href_next  = (state_next == ACTIVE) && (h_next < HREF_END);
`ifdef PIX_GAP_EN
    clken_next = href_next && !h_next[0];
`else
    clken_next = href_next;
`endif
    done_next  = (state_next == VFP) && (v_next == VW'(V_FP - 1)) && (h_next == H_LAST);
    y_next     = 8'h00;
    if (href_next) begin
      case (sel_reg)
        2'd0:    y_next = x8;
        2'd1:    y_next = y8;
        2'd2:    y_next = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
        default: y_next = cval_reg;
      endcase
    end
  end

  // State, counters, per-frame pattern latch and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      h_reg           <= '0;
      v_reg           <= '0;
      sel_reg         <= 2'd0;
      cval_reg        <= 8'h00;
      per_frame_vsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_frame_clken <= 1'b0;
      per_img_y       <= 8'h00;
      frame_done      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      h_reg           <= h_next;
      v_reg           <= v_next;
      // Pattern selection is frozen for the frame on entry to VSYNC
      if (state_next == VSYNC && state_reg != VSYNC) begin
        sel_reg  <= pattern_sel;
        cval_reg <= const_val;
      end
      per_frame_vsync <= vsync_next;
      per_frame_href  <= href_next;
      per_frame_clken <= clken_next;
      per_img_y       <= y_next;
      frame_done      <= done_next;
    end
  end

endmodule

// File: tb/tb_pic_stream_pattern_gen.sv
// tb_pic_stream_pattern_gen
// Small-geometry bench: H_ACTIVE=4, H_BLANK=3, V_SYNC=1, V_BP=1,
// V_ACTIVE=3, V_FP=1. Honors PIX_GAP_EN for the two-cycle pixel build.
module tb_pic_stream_pattern_gen;

`ifdef PIX_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  localparam int PIXC = GAP + 1;
  localparam int HREF = 4 * PIXC;
  localparam int HT   = HREF + 3;
  localparam int FR   = 6 * HT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] const_val = 8'h00;
  logic       per_frame_vsync, per_frame_href, per_frame_clken, frame_done;
  logic [7:0] per_img_y;

  int n_cmp = 0;
  int n_bad = 0;

  pic_stream_pattern_gen #(
    .H_ACTIVE(4), .H_BLANK(3), .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .const_val(const_val), .per_frame_vsync(per_frame_vsync),
    .per_frame_href(per_frame_href), .per_frame_clken(per_frame_clken),
    .per_img_y(per_img_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [7:0]  cval;
    logic [95:0] pix;   // byte k = k-th active pixel (line*4 + x)
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outs();
    return {per_frame_vsync, per_frame_href, per_frame_clken, frame_done, per_img_y};
  endfunction

  task automatic cmp(input string name, input int a, input int b,
                     input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d.%0d] got {vs,href,ck,done,y}=%03h required %03h", name, a, b, got, exp);
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      cmp(name, c, 0, outs(), 12'h000);
    end
  endtask

  // One full frame, started/continued from a frame boundary
  task automatic check_frame(input int idx, input bit drop_mid);
    int p, ln, h, x, nck;
    logic ev, eh, ec, ed;
    logic [7:0] ey;
    pattern_sel = tbl[idx].sel;
    const_val   = tbl[idx].cval;
    enable      = 1'b1;
    nck = 0;
    for (int c = 1; c <= FR; c++) begin
      tick();
      p  = c - 1;
      ln = p / HT;
      h  = p % HT;
      x  = h / PIXC;
      ev = (ln == 0);
      eh = (ln >= 2) && (ln <= 4) && (h < HREF);
      ec = eh && ((GAP == 0) || (h % 2 == 0));
      ed = (c == FR);
      ey = eh ? tbl[idx].pix[((ln - 2) * 4 + x) * 8 +: 8] : 8'h00;
      if (per_frame_clken) nck++;
      cmp("frame", idx, c, outs(), {ev, eh, ec, ed, ey});
      if (drop_mid && c == 3 * HT) begin
        enable      = 1'b0;
        pattern_sel = 2'd1;
        const_val   = 8'h3C;
      end
    end
    cmp("clken_count", idx, 0, 12'(nck), 12'd12);
  endtask

  initial begin
    tbl[0] = '{sel: 2'd0, cval: 8'h00, pix: 96'h030201000302010003020100};
    tbl[1] = '{sel: 2'd1, cval: 8'h77, pix: 96'h020202020101010100000000};
    tbl[2] = '{sel: 2'd3, cval: 8'hA5, pix: 96'hA5A5A5A5A5A5A5A5A5A5A5A5};
    tbl[3] = '{sel: 2'd2, cval: 8'h11, pix: 96'h000000000000000000000000};
    tbl[4] = '{sel: 2'd0, cval: 8'h5A, pix: 96'h030201000302010003020100};

    // Reset, then hold enable low: everything stays quiet
    repeat (3) tick();
    rst = 1'b0;
    check_idle("idle_after_rst", 100);

    // Back-to-back frames across patterns; last one drops enable mid-ACTIVE
    for (int i = 0; i < 5; i++)
      check_frame(i, i == 4);
    check_idle("idle_after_drop", 10);

    // Reset in the middle of active line 2
    pattern_sel = 2'd0;
    enable      = 1'b1;
    repeat (3 * HT + 2) tick();
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    cmp("rst_mid", 0, 0, outs(), 12'h000);
    rst = 1'b0;
    check_idle("idle_after_mid_rst", 20);

    // Restart from IDLE, then let it stop
    check_frame(0, 1'b0);
    enable = 1'b0;
    check_idle("idle_end", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
